dcache_assoc_storage: RTL and testbench

//  Parametrised N-way set-associative data-cache storage: data, tag, valid and dirty arrays.

---
 rtl/dcache_assoc_storage.sv | 236 +++++++++++++++++++++++
 tb/tb_dcache_assoc_storage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc_storage.sv
// N-way set-associative D-cache storage: data/tag block RAMs, valid/dirty/round-robin flops,
// one-cycle lookup with hit/victim reporting, byte-masked stores and an invalidate-all sequencer.
module dcache_assoc_storage #(
  parameter int DWORD_OFFSET_WIDTH = 3,
  parameter int LINE_WIDTH         = 6,
  parameter int WAYS               = 2,
  parameter int ADDR_WIDTH         = 32,
  localparam int BLOCK = 1 << DWORD_OFFSET_WIDTH,
  localparam int SETS  = 1 << LINE_WIDTH,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int TAG_W = ADDR_WIDTH - LINE_WIDTH - DWORD_OFFSET_WIDTH - 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_resp_valid,
  output logic                    rd_hit,
  output logic [WAY_W-1:0]        rd_way,
  output logic [63:0]             rd_data,
  output logic [TAG_W-1:0]        rd_victim_tag,
  output logic                    rd_victim_dirty,
  input  logic                    refill_valid,
  input  logic [LINE_WIDTH-1:0]   refill_index,
  input  logic [WAY_W-1:0]        refill_way,
  input  logic [TAG_W-1:0]        refill_tag,
  input  logic [64*BLOCK-1:0]     refill_block,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [WAY_W-1:0]        st_way,
  input  logic [63:0]             st_data,
  input  logic [7:0]              st_strb,
  input  logic                    inv_req,
  output logic                    inv_busy,
  output logic                    inv_done
);

  typedef enum logic {S_IDLE, S_INV} state_t;

  state_t                  state_q, state_d;
  logic [LINE_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    inv_done_q, inv_done_d;

  logic rd_fire, refill_fire, st_fire;
  logic [LINE_WIDTH-1:0]         rd_idx, st_idx, wr_idx;
  logic [DWORD_OFFSET_WIDTH-1:0] rd_off, st_off;
  logic [TAG_W-1:0]              rd_tag;
  logic                          unused_addr_bits;

  logic [WAYS-1:0][SETS-1:0]     valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAY_W-1:0]    rr_q;

  logic                          resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]              req_tag_q, req_tag_d;
  logic [DWORD_OFFSET_WIDTH-1:0] off_q, off_d;
  logic [WAYS-1:0]               valid_rd_q, valid_rd_d, dirty_rd_q, dirty_rd_d;
  logic [WAY_W-1:0]              rr_rd_q, rr_rd_d;

  logic [WAYS-1:0][TAG_W-1:0]            tag_rd;
  logic [WAYS-1:0][BLOCK-1:0][63:0]      data_rd;

  assign inv_busy    = (state_q == S_INV);
  assign inv_done    = inv_done_q;
  assign rd_ready    = !inv_busy && !reset;
  assign st_ready    = !inv_busy && !refill_valid && !reset;
  assign rd_fire     = rd_valid && rd_ready;
  assign refill_fire = refill_valid && !inv_busy && !reset;
  assign st_fire     = st_valid && st_ready;

  assign rd_idx = rd_addr[DWORD_OFFSET_WIDTH+3 +: LINE_WIDTH];
  assign rd_off = rd_addr[3 +: DWORD_OFFSET_WIDTH];
  assign rd_tag = rd_addr[ADDR_WIDTH-1 -: TAG_W];
  assign st_idx = st_addr[DWORD_OFFSET_WIDTH+3 +: LINE_WIDTH];
  assign st_off = st_addr[3 +: DWORD_OFFSET_WIDTH];
  assign wr_idx = refill_fire ? refill_index : st_idx;
  assign unused_addr_bits = ^{rd_addr[2:0], st_addr[2:0], st_addr[ADDR_WIDTH-1 -: TAG_W]};

  // One write port per RAM: refill drives every lane of a way, a store drives one lane's bytes.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [TAG_W-1:0] tag_rd_q;

    always_ff @(posedge clock) begin
      if (refill_fire && refill_way == WAY_W'(gi))
        tag_mem[refill_index] <= refill_tag;
      tag_rd_q <= tag_mem[rd_idx];
    end
    assign tag_rd[gi] = tag_rd_q;

    for (genvar gj = 0; gj < BLOCK; gj++) begin : g_lane
      logic [63:0] data_mem [SETS];
      logic [63:0] data_rd_q;
      logic [7:0]  be;
      logic [63:0] wdata;

      assign be = (refill_fire && refill_way == WAY_W'(gi)) ? 8'hFF :
                  (st_fire && st_way == WAY_W'(gi) && st_off == DWORD_OFFSET_WIDTH'(gj)) ? st_strb :
                  8'h00;
      assign wdata = refill_fire ? refill_block[64*gj +: 64] : st_data;

      always_ff @(posedge clock) begin
        for (int b = 0; b < 8; b++)
          if (be[b]) data_mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        data_rd_q <= data_mem[rd_idx];
      end
      assign data_rd[gi][gj] = data_rd_q;
    end
  end

  if (WAYS > 1) begin : g_rr
    logic [SETS-1:0][WAY_W-1:0] rr_d;
    always_comb begin
      rr_d = rr_q;
      if (refill_fire && refill_way == rr_q[refill_index])
        rr_d[refill_index] = rr_q[refill_index] + WAY_W'(1);
    end
    always_ff @(posedge clock) begin
      if (reset) rr_q <= '0;
      else       rr_q <= rr_d;
    end
  end else begin : g_no_rr
    assign rr_q = '0;
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (inv_busy) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_d[w][cnt_q] = 1'b0;
        dirty_d[w][cnt_q] = 1'b0;
      end
    end else if (refill_fire) begin
      valid_d[refill_way][refill_index] = 1'b1;
      dirty_d[refill_way][refill_index] = 1'b0;
    end else if (st_fire) begin
      dirty_d[st_way][st_idx] = 1'b1;
    end
  end

  // Lookup side-band is sampled with pre-write state, giving read-first behaviour.
  always_comb begin
    resp_valid_d = rd_fire;
    req_tag_d    = rd_tag;
    off_d        = rd_off;
    rr_rd_d      = rr_q[rd_idx];
    for (int w = 0; w < WAYS; w++) begin
      valid_rd_d[w] = valid_q[w][rd_idx];
      dirty_rd_d[w] = dirty_q[w][rd_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_done_d = 1'b0;
    case (state_q)
      S_IDLE: if (inv_req) begin
        state_d = S_INV;
        cnt_d   = '0;
      end
      S_INV: if (cnt_q == LINE_WIDTH'(SETS - 1)) begin
        state_d    = S_IDLE;
        inv_done_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + LINE_WIDTH'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      inv_done_q   <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      resp_valid_q <= 1'b0;
      req_tag_q    <= '0;
      off_q        <= '0;
      valid_rd_q   <= '0;
      dirty_rd_q   <= '0;
      rr_rd_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inv_done_q   <= inv_done_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      resp_valid_q <= resp_valid_d;
      req_tag_q    <= req_tag_d;
      off_q        <= off_d;
      valid_rd_q   <= valid_rd_d;
      dirty_rd_q   <= dirty_rd_d;
      rr_rd_q      <= rr_rd_d;
    end
  end

  // Lowest matching way wins; on a miss the lowest invalid way beats the round-robin pointer.
  always_comb begin
    logic [WAY_W-1:0] hit_way, victim_way;
    logic             any_hit;
    rd_resp_valid   = resp_valid_q;
    rd_hit          = 1'b0;
    rd_way          = '0;
    rd_data         = '0;
    rd_victim_tag   = '0;
    rd_victim_dirty = 1'b0;
    any_hit         = 1'b0;
    hit_way         = '0;
    victim_way      = rr_rd_q;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_rd_q[w] && tag_rd[w] == req_tag_q) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_rd_q[w]) victim_way = WAY_W'(w);
    end
    if (resp_valid_q) begin
      rd_hit = any_hit;
      if (any_hit) begin
        rd_way  = hit_way;
        rd_data = data_rd[hit_way][off_q];
      end else begin
        rd_way          = victim_way;
        rd_victim_tag   = tag_rd[victim_way];
        rd_victim_dirty = valid_rd_q[victim_way] && dirty_rd_q[victim_way];
      end
    end
  end

endmodule

// File: tb/tb_dcache_assoc_storage.sv
// Directed bench for dcache_assoc_storage (default parameters: 2 ways, 64 sets, 8 dwords/block).
module tb_dcache_assoc_storage;

  logic         clock = 1'b0;
  logic         reset;
  logic         rd_valid;
  logic         rd_ready;
  logic [31:0]  rd_addr;
  logic         rd_resp_valid;
  logic         rd_hit;
  logic [0:0]   rd_way;
  logic [63:0]  rd_data;
  logic [19:0]  rd_victim_tag;
  logic         rd_victim_dirty;
  logic         refill_valid;
  logic [5:0]   refill_index;
  logic [0:0]   refill_way;
  logic [19:0]  refill_tag;
  logic [511:0] refill_block;
  logic         st_valid;
  logic         st_ready;
  logic [31:0]  st_addr;
  logic [0:0]   st_way;
  logic [63:0]  st_data;
  logic [7:0]   st_strb;
  logic         inv_req;
  logic         inv_busy;
  logic         inv_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dcache_assoc_storage dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_hit(rd_hit), .rd_way(rd_way), .rd_data(rd_data),
    .rd_victim_tag(rd_victim_tag), .rd_victim_dirty(rd_victim_dirty),
    .refill_valid(refill_valid), .refill_index(refill_index), .refill_way(refill_way),
    .refill_tag(refill_tag), .refill_block(refill_block),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_way(st_way),
    .st_data(st_data), .st_strb(st_strb),
    .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic lookup(input logic [31:0] addr);
    rd_valid = 1'b1;
    rd_addr  = addr;
    step();
    rd_valid = 1'b0;
  endtask

  task automatic set_refill(input logic [5:0] idx, input logic w, input logic [19:0] tag,
                            input logic [63:0] base);
    refill_valid = 1'b1;
    refill_index = idx;
    refill_way   = w;
    refill_tag   = tag;
    for (int j = 0; j < 8; j++) refill_block[64*j +: 64] = base + 64'(j);
  endtask

  task automatic refill(input logic [5:0] idx, input logic w, input logic [19:0] tag,
                        input logic [63:0] base);
    set_refill(idx, w, tag, base);
    step();
    refill_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic w, input logic [63:0] data,
                       input logic [7:0] strb);
    st_valid = 1'b1;
    st_addr  = addr;
    st_way   = w;
    st_data  = data;
    st_strb  = strb;
    step();
    st_valid = 1'b0;
  endtask

  task automatic chk_miss(input string tag, input logic w, input logic [19:0] vtag);
    chk({tag, "_resp"}, 64'(rd_resp_valid), 64'd1);
    chk({tag, "_hit"}, 64'(rd_hit), 64'd0);
    chk({tag, "_way"}, 64'(rd_way), 64'(w));
    chk({tag, "_vtag"}, 64'(rd_victim_tag), 64'(vtag));
  endtask

  initial begin
    int busy_cycles;
    int done_cnt;
    bit ready_bad;
    bit done_seen;

    reset = 1'b1; rd_valid = 1'b0; rd_addr = '0;
    refill_valid = 1'b0; refill_index = '0; refill_way = '0; refill_tag = '0; refill_block = '0;
    st_valid = 1'b0; st_addr = '0; st_way = '0; st_data = '0; st_strb = '0; inv_req = 1'b0;
    step(); step();

    chk("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
    chk("rst_hit", 64'(rd_hit), 64'd0);
    chk("rst_way", 64'(rd_way), 64'd0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_inv_busy", 64'(inv_busy), 64'd0);
    chk("rst_inv_done", 64'(inv_done), 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_rd_ready", 64'(rd_ready), 64'd1);

    // Cold miss: both ways invalid, lowest way is the victim.
    lookup(32'h0000_1000);
    chk("cold_resp", 64'(rd_resp_valid), 64'd1);
    chk("cold_hit", 64'(rd_hit), 64'd0);
    chk("cold_way", 64'(rd_way), 64'd0);
    chk("cold_vdirty", 64'(rd_victim_dirty), 64'd0);
    step();
    chk("resp_one_cycle", 64'(rd_resp_valid), 64'd0);

    refill(6'd0, 1'b1, 20'h1, 64'd1);
    lookup(32'h0000_1018);
    chk("refill_hit", 64'(rd_hit), 64'd1);
    chk("refill_way", 64'(rd_way), 64'd1);
    chk("refill_data", rd_data, 64'd4);

    store(32'h0000_1018, 1'b1, 64'hAABBCCDD_11223344, 8'h0F);
    lookup(32'h0000_1018);
    chk("store_hit", 64'(rd_hit), 64'd1);
    chk("store_data", rd_data, 64'h00000000_11223344);

    // Way 0 refill advances set 0 pointer to 1, so way 1 (dirty) becomes the victim.
    refill(6'd0, 1'b0, 20'h2, 64'h100);
    lookup(32'h0000_2008);
    chk("way0_hit", 64'(rd_hit), 64'd1);
    chk("way0_way", 64'(rd_way), 64'd0);
    chk("way0_data", rd_data, 64'h101);
    lookup(32'h0000_3000);
    chk_miss("dirty_victim", 1'b1, 20'h1);
    chk("dirty_victim_vdirty", 64'(rd_victim_dirty), 64'd1);
    chk("dirty_victim_data", rd_data, 64'd0);

    // Set 5 round-robin sequence.
    lookup(32'h0001_0140);
    chk_miss("rr_a", 1'b0, rd_victim_tag);
    refill(6'd5, 1'b0, 20'h10, 64'h500);
    lookup(32'h0001_1140);
    chk("rr_b_way", 64'(rd_way), 64'd1);
    chk("rr_b_hit", 64'(rd_hit), 64'd0);
    refill(6'd5, 1'b1, 20'h11, 64'h510);
    lookup(32'h0001_2140);
    chk_miss("rr_c", 1'b0, 20'h10);
    chk("rr_c_vdirty", 64'(rd_victim_dirty), 64'd0);
    refill(6'd5, 1'b0, 20'h12, 64'h520);
    lookup(32'h0001_3140);
    chk_miss("rr_d", 1'b1, 20'h11);
    refill(6'd5, 1'b1, 20'h13, 64'h530);
    lookup(32'h0001_4140);
    chk_miss("rr_e", 1'b0, 20'h12);

    // Lookup and refill to set 7 in the same cycle: read-first.
    rd_valid = 1'b1;
    rd_addr  = 32'h0002_01C0;
    set_refill(6'd7, 1'b0, 20'h20, 64'h700);
    step();
    rd_valid = 1'b0;
    refill_valid = 1'b0;
    chk("rf_same_hit", 64'(rd_hit), 64'd0);
    chk("rf_same_resp", 64'(rd_resp_valid), 64'd1);
    lookup(32'h0002_01C8);
    chk("rf_next_hit", 64'(rd_hit), 64'd1);
    chk("rf_next_data", rd_data, 64'h701);

    // Store blocked by a concurrent refill.
    set_refill(6'd9, 1'b0, 20'h30, 64'h900);
    st_valid = 1'b1; st_addr = 32'h0000_1018; st_way = 1'b1;
    st_data = 64'hFFFF_FFFF_FFFF_FFFF; st_strb = 8'hFF;
    #1;
    chk("st_blocked_ready", 64'(st_ready), 64'd0);
    step();
    st_valid = 1'b0;
    refill_valid = 1'b0;
    lookup(32'h0000_1018);
    chk("st_blocked_data", rd_data, 64'h00000000_11223344);
    lookup(32'h0003_0240);
    chk("st_blocked_refill_data", rd_data, 64'h900);

    // Invalidate-all, with a lookup accepted in the request cycle.
    rd_valid = 1'b1; rd_addr = 32'h0000_1018; inv_req = 1'b1;
    step();
    rd_valid = 1'b0; inv_req = 1'b0;
    chk("inv_pending_resp", 64'(rd_resp_valid), 64'd1);
    chk("inv_pending_hit", 64'(rd_hit), 64'd1);
    chk("inv_pending_data", rd_data, 64'h00000000_11223344);
    busy_cycles = 0; ready_bad = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      if (inv_busy) begin
        busy_cycles++;
        if (rd_ready) ready_bad = 1'b1;
      end
      if (inv_done) done_seen = 1'b1;
      else step();
    end
    chk("inv_busy_cycles", 64'(busy_cycles), 64'd64);
    chk("inv_ready_low", 64'(ready_bad), 64'd0);
    chk("inv_done_seen", 64'(done_seen), 64'd1);
    chk("inv_busy_at_done", 64'(inv_busy), 64'd0);
    step();
    chk("inv_done_pulse", 64'(inv_done), 64'd0);
    lookup(32'h0000_1018);
    chk("inv_miss_a", 64'(rd_hit), 64'd0);
    lookup(32'h0000_2000);
    chk("inv_miss_b", 64'(rd_hit), 64'd0);
    lookup(32'h0003_0240);
    chk("inv_miss_c", 64'(rd_hit), 64'd0);

    // Reset in the tenth INV cycle.
    refill(6'd3, 1'b1, 20'h44, 64'h300);
    inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("mid_inv_busy", 64'(inv_busy), 64'd1);
    reset = 1'b1;
    step();
    chk("rst_inv_busy_cleared", 64'(inv_busy), 64'd0);
    chk("rst_inv_no_done", 64'(inv_done), 64'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      if (inv_done || inv_busy) done_cnt++;
      step();
    end
    chk("rst_inv_quiet", 64'(done_cnt), 64'd0);
    lookup(32'h0004_40C0);
    chk("rst_inv_line_gone", 64'(rd_hit), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
